// File: rtl/pulse_burst_gen.sv
// Programmable pulse-train transmitter: on an accepted start it emits burst_len pulses,
// each high_len cycles high and separated by gap_len low cycles, then pulses done.
// Every output is registered from the next-state logic, so out_sig follows start by one cycle.
module pulse_burst_gen #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] gap_len,
  output logic             out_sig,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [LEN_W-1:0]   high_q, high_d;
  logic [LEN_W-1:0]   gap_q, gap_d;
  // Cycles remaining in the current HIGH/LOW phase after this one.
  logic [LEN_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic               aborted_d;
  logic               out_sig_q, busy_q, done_q, aborted_q;

  // Zero-length phases are stretched to one cycle so each pulse is a distinct rising edge.
  logic [LEN_W-1:0]   high_clamp, gap_clamp;
  assign high_clamp = (high_len == '0) ? LEN_W'(1) : high_len;
  assign gap_clamp  = (gap_len == '0) ? LEN_W'(1) : gap_len;

  // Next-state, latched-parameter and counter logic.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    high_d      = high_q;
    gap_d       = gap_q;
    phase_d     = phase_q;
    pulse_cnt_d = pulse_cnt_q;
    aborted_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort beats start in the same cycle: nothing is latched.
        if (start && !abort) begin
          burst_d     = burst_len;
          high_d      = high_clamp;
          gap_d       = gap_clamp;
          pulse_cnt_d = '0;
          if (burst_len != '0) begin
            state_d     = StHigh;
            pulse_cnt_d = CNT_W'(1);
            phase_d     = high_clamp - LEN_W'(1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StHigh: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          if (pulse_cnt_q == burst_q) begin
            state_d = StDone;
          end else begin
            state_d = StLow;
            phase_d = gap_q - LEN_W'(1);
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StLow: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (phase_q == '0) begin
          state_d     = StHigh;
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
          phase_d     = high_q - LEN_W'(1);
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StDone: begin
        // abort is ignored here; completion always reports.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      high_q      <= '0;
      gap_q       <= '0;
      phase_q     <= '0;
      pulse_cnt_q <= '0;
      out_sig_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      high_q      <= high_d;
      gap_q       <= gap_d;
      phase_q     <= phase_d;
      pulse_cnt_q <= pulse_cnt_d;
      out_sig_q   <= (state_d == StHigh);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      aborted_q   <= aborted_d;
    end
  end

  assign out_sig   = out_sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Bench for pulse_burst_gen: a schedule model derived from burst arithmetic is checked
// every cycle, and directed bursts are additionally pinned against hand-computed waveforms.
module tb_pulse_burst_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] burst_len = '0;
  logic [3:0] high_len = '0;
  logic [3:0] gap_len = '0;
  logic       out_sig, busy, done, aborted;
  logic [2:0] pulse_cnt;

  int total = 0;
  int bad = 0;

  pulse_burst_gen #(.CNT_W(3), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .burst_len (burst_len),
    .high_len  (high_len),
    .gap_len   (gap_len),
    .out_sig   (out_sig),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst accepted in cycle t0 occupies cycles t0+1 .. t0+D with
  // D = N*H + (N-1)*G + 1 (or 1 for N=0); cycle t0+D is the done cycle.
  int  cyc = 0, t0 = 0, mn = 0, mh = 1, mg = 1, md = 1, held = 0, cur = 0, off = 0;
  bit  act = 0, ab = 0, valid = 0;
  logic e_out = 0, e_busy = 0, e_done = 0, e_ab = 0;
  int  e_cnt = 0;

  initial forever begin
    @(posedge clk);
    cur = cyc;
    cyc++;
    ab = 0;
    if (rst) begin
      act = 0;
      held = 0;
      valid = 1;
    end else if (act) begin
      off = cur - t0;
      if (off == md) begin
        act = 0;
        held = mn;
      end else if (abort) begin
        act = 0;
        ab = 1;
        held = (off - 1) / (mh + mg) + 1;
      end
    end else if (start && !abort) begin
      act = 1;
      t0 = cur;
      mn = int'(burst_len);
      mh = (high_len == 0) ? 1 : int'(high_len);
      mg = (gap_len == 0) ? 1 : int'(gap_len);
      md = (mn == 0) ? 1 : mn * mh + (mn - 1) * mg + 1;
    end
    if (act) begin
      off = cyc - t0;
      e_busy = 1;
      e_ab = 0;
      if (off == md) begin
        e_out = 0;
        e_done = 1;
        e_cnt = mn;
      end else begin
        e_done = 0;
        e_out = ((off - 1) % (mh + mg)) < mh;
        e_cnt = (off - 1) / (mh + mg) + 1;
      end
    end else begin
      e_out = 0;
      e_busy = 0;
      e_done = 0;
      e_ab = ab;
      e_cnt = held;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (valid) begin
      chk("model", {25'd0, out_sig, busy, done, aborted, pulse_cnt},
          {25'd0, e_out, e_busy, e_done, e_ab, 3'(e_cnt)});
    end
  end

  // Launch a burst in the current cycle and record outputs for cycles 1..len.
  // Lengths are scrambled after acceptance to show they are not re-sampled.
  task automatic run(input int n, input int h, input int g, input int len,
                     input int ab_at, input int st_at, input int rs_at,
                     output logic [31:0] ov, output logic [31:0] dv,
                     output logic [31:0] av, output logic [31:0] bv, output int pc);
    ov = '0; dv = '0; av = '0; bv = '0; pc = 0;
    burst_len = 3'(n);
    high_len = 4'(h);
    gap_len = 4'(g);
    start = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      start = (i == st_at);
      abort = (i == ab_at);
      rst = (i == rs_at);
      if (i == 1) begin
        burst_len = 3'd7;
        high_len = 4'd15;
        gap_len = 4'd15;
      end
      ov[i] = out_sig;
      dv[i] = done;
      av[i] = aborted;
      bv[i] = busy;
      pc = int'(pulse_cnt);
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
  endtask

  logic [31:0] ov, dv, av, bv;
  int pc;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, out_sig, busy, done, aborted, 1'b0}, 32'd0);
    chk("reset_cnt", 32'(pulse_cnt), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_outputs", {28'd0, out_sig, busy, done, aborted}, 32'd0);

    // Dense burst, then an immediate start in the first IDLE cycle.
    run(3, 1, 1, 7, 0, 0, 0, ov, dv, av, bv, pc);
    chk("dense_out", ov, 32'h2A);
    chk("dense_done", dv, 32'h40);
    chk("dense_busy", bv, 32'h7E);
    chk("dense_cnt", 32'(pc), 32'd3);

    // Gap clamped from 0 to 1.
    run(3, 2, 0, 10, 0, 0, 0, ov, dv, av, bv, pc);
    chk("clamp_out", ov, 32'h1B6);
    chk("clamp_done", dv, 32'h200);
    chk("clamp_cnt", 32'(pc), 32'd3);

    run(3, 2, 2, 12, 0, 0, 0, ov, dv, av, bv, pc);
    chk("sparse_out", ov, 32'h666);
    chk("sparse_done", dv, 32'h800);

    // High clamped from 0 to 1.
    run(2, 0, 3, 8, 0, 0, 0, ov, dv, av, bv, pc);
    chk("hclamp_out", ov, 32'h22);
    chk("hclamp_done", dv, 32'h40);

    run(0, 3, 3, 3, 0, 0, 0, ov, dv, av, bv, pc);
    chk("zero_out", ov, 32'h0);
    chk("zero_done", dv, 32'h2);
    chk("zero_busy", bv, 32'h2);
    chk("zero_cnt", 32'(pc), 32'd0);

    // Abort in cycle 4 with a spurious start in cycle 2.
    run(5, 1, 1, 7, 4, 2, 0, ov, dv, av, bv, pc);
    chk("abort_out", ov, 32'hA);
    chk("abort_done", dv, 32'h0);
    chk("abort_flag", av, 32'h20);
    chk("abort_busy", bv, 32'h1E);
    chk("abort_cnt", 32'(pc), 32'd2);

    // start and abort together in IDLE: ignored, count holds.
    burst_len = 3'd3;
    high_len = 4'd1;
    gap_len = 4'd1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    chk("start_abort_cnt", 32'(pulse_cnt), 32'd2);

    // Reset during cycle 3 of a four-pulse burst.
    run(4, 1, 1, 6, 0, 0, 3, ov, dv, av, bv, pc);
    chk("rst_mid_out", ov & 32'h70, 32'h0);
    chk("rst_mid_busy", bv & 32'h70, 32'h0);
    chk("rst_mid_flags", dv | av, 32'h0);
    chk("rst_mid_cnt", 32'(pc), 32'd0);

    run(3, 1, 1, 7, 0, 0, 0, ov, dv, av, bv, pc);
    chk("after_rst_out", ov, 32'h2A);
    chk("after_rst_done", dv, 32'h40);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
Programmable pulse-train transmitter that drives the single-bit event line consumed by the team's windowed rising-edge checker. On a start request it emits burst_len rising edges on out_sig, each pulse high for high_len cycles and separated by gap_len low cycles. It then reports completion. It is used as the on-chip stimulus source and loopback driver for the edge-window detection path.

Parameters:
CNT_W, 3, width of burst_len and pulse_cnt (max burst 2^CNT_W-1 pulses)
LEN_W, 4, width of high_len and gap_len (max 2^LEN_W-1 cycles per phase)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  burst request, sampled only in IDLE
abort  input  1  synchronous cancel of an in-progress burst
burst_len  input  CNT_W  number of pulses, latched on start acceptance
high_len  input  LEN_W  high-phase cycles per pulse, latched on acceptance
gap_len  input  LEN_W  low-phase cycles between pulses, latched on acceptance
out_sig  output  1  registered pulse-train output
busy  output  1  high while any state other than IDLE
done  output  1  one-cycle pulse on normal burst completion
aborted  output  1  one-cycle pulse when a burst is cancelled
pulse_cnt  output  CNT_W  rising edges emitted in current/last burst

Behaviour:
- Reset: rst sampled high at posedge sets state=IDLE and out_sig=busy=done=aborted=0. It also clears pulse_cnt and all latched length/phase counters. Reset mid-burst takes effect at that edge, with no done or aborted pulse.
- Only one clock domain exists and every output is registered. There is no combinational path from any input to any output.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE: out_sig=0, busy=0.
  - start=1 and abort=0 at edge T: latch the three lengths, clear pulse_cnt.
  - burst_len!=0: go to HIGH at T+1, giving out_sig=1 in cycle T+1 (one-cycle latency).
  - burst_len==0: go directly to DONE, with no pulse emitted.
- Length clamping: latched high_len==0 is treated as 1 and latched gap_len==0 is treated as 1. out_sig is therefore always low at least one cycle between pulses, so every pulse is a distinct rising edge.
- HIGH: out_sig=1 for exactly H cycles.
  - pulse_cnt increments on entry, in the same cycle out_sig first goes high.
  - On the last high cycle, if pulse_cnt==burst_len go to DONE, else go to LOW.
- LOW: out_sig=0 for exactly G cycles, then go to HIGH.
- DONE: lasts one cycle with out_sig=0, done=1, busy=1, then go to IDLE. No LOW phase follows the final pulse.
- Burst duration, start accept to done inclusive: N*H + (N-1)*G + 1 cycles for N>=1.
- start seen while busy=1 is ignored: not queued, no effect on latched values. Input length changes during a burst have no effect.
- abort=1 in HIGH or LOW: next cycle state=IDLE, out_sig=0, aborted=1 for one cycle, done=0, busy=0. pulse_cnt holds the count reached.
- abort in DONE: ignored, done still completes.
- abort in IDLE: no effect. With start in the same IDLE cycle, abort wins, start is ignored and nothing is latched.
- done and aborted are never high in the same cycle.
- A new start is accepted in the first IDLE cycle after DONE, so back-to-back bursts are separated by one low DONE cycle plus the IDLE cycle.
- pulse_cnt never wraps within a burst (bounded by burst_len). It holds its value in IDLE until the next accepted start.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_sig=busy=done=aborted=0, pulse_cnt=0. start held low 10 cycles -> all outputs stay 0.
- Dense burst: burst_len=3, high_len=1, gap_len=1, start at cycle 0 -> out_sig=1,0,1,0,1 in cycles 1-5. Cycle 6: out_sig=0, done=1, busy=1. Cycle 7: busy=0, pulse_cnt=3. Looped into the edge-window checker, this gives exactly one hit.
- Sparse burst with clamping: burst_len=3, high_len=2, gap_len=0 -> rises at cycles 1,4,7, each high 2 cycles, low 1 cycle, done at cycle 9. Rerun with gap_len=2 -> rises at 1,5,9, done at 11. Checker gives no hit.
- Zero length: burst_len=0 -> out_sig stays 0, done=1 in cycle 1, busy=0 in cycle 2, pulse_cnt=0.
- Abort/start interaction: start burst_len=5,H=1,G=1, assert abort in cycle 4 -> cycle 5 out_sig=0, aborted=1, busy=0, pulse_cnt=2, no done. Start pulses during busy are ignored. start+abort together in IDLE -> nothing happens.
- Reset mid-burst: rst=1 in cycle 3 of a burst_len=4 burst -> next cycle all outputs 0, no done/aborted. A new start is accepted normally right after rst is released.
